// File: rtl/branch_pred_pkg.sv
// Shared types and helpers for the branch predictor: counter encodings,
// saturating counter step and table index hashing.
package branch_pred_pkg;

    localparam int unsigned BP_W = 64;

    typedef logic [BP_W-1:0] bp_word_t;

    // Counter encodings for the 2-bit case.
    typedef enum logic [1:0] {
        STRONG_NT = 2'd0,
        WEAK_NT   = 2'd1,
        WEAK_T    = 2'd2,
        STRONG_T  = 2'd3
    } ctr2_e;

    function automatic bp_word_t ctr_init(input int unsigned ctr_bits);
        return bp_word_t'(1) << (ctr_bits - 1);
    endfunction

    function automatic bp_word_t sat_next(input bp_word_t ctr, input logic taken,
                                          input int unsigned ctr_bits);
        bp_word_t max_v;
        max_v = (bp_word_t'(1) << ctr_bits) - bp_word_t'(1);
        if (taken) begin
            return (ctr >= max_v) ? max_v : ctr + bp_word_t'(1);
        end
        return (ctr == '0) ? '0 : ctr - bp_word_t'(1);
    endfunction

    // Global history is zero-extended by the caller before the XOR.
    function automatic bp_word_t bp_index(input bp_word_t pc, input bp_word_t ghr,
                                          input int unsigned pc_lsb,
                                          input int unsigned index_bits);
        bp_word_t mask;
        mask = (bp_word_t'(1) << index_bits) - bp_word_t'(1);
        return ((pc >> pc_lsb) ^ ghr) & mask;
    endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: valid/tag/target arrays with one
// combinational read port and one synchronous write port.
module branch_target_buffer
    import branch_pred_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 3,
    parameter int unsigned TAG_W      = 27,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INDEX_BITS-1:0] rd_idx_i,
    input  logic [TAG_W-1:0]      rd_tag_i,
    output logic                  rd_hit_o,
    output logic [ADDR_WIDTH-1:0] rd_target_o,
    input  logic                  wr_en_i,
    input  logic [INDEX_BITS-1:0] wr_idx_i,
    input  logic [TAG_W-1:0]      wr_tag_i,
    input  logic [ADDR_WIDTH-1:0] wr_target_i
);

    localparam int unsigned ENTRIES = 1 << INDEX_BITS;

    logic [ENTRIES-1:0]    valid_q;
    logic [TAG_W-1:0]      tag_q    [ENTRIES];
    logic [ADDR_WIDTH-1:0] target_q [ENTRIES];

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag and target payloads need no reset; valid gates every read.
    always_ff @(posedge clk) begin
        if (reset && wr_en_i) begin
            tag_q[wr_idx_i]    <= wr_tag_i;
            target_q[wr_idx_i] <= wr_target_i;
        end
    end

    assign rd_hit_o    = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
    assign rd_target_o = target_q[rd_idx_i];

endmodule

// File: rtl/branch_predictor_bht.sv
// Branch predictor: saturating-counter BHT plus BTB, optional gshare indexing,
// zero-latency IF lookup and EX-stage resolve with flush/redirect generation.
module branch_predictor_bht
    import branch_pred_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned INDEX_BITS = 3,
    parameter int unsigned CTR_BITS   = 2,
    parameter int unsigned PC_LSB     = 2,
    parameter int unsigned GHR_BITS   = 0,
    localparam int unsigned GW        = (GHR_BITS > 0) ? GHR_BITS : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  lookup_valid,
    input  logic [ADDR_WIDTH-1:0] lookup_pc,
    output logic                  pred_taken,
    output logic [ADDR_WIDTH-1:0] pred_target,
    output logic [GW-1:0]         pred_ghr,
    input  logic                  resolve_valid,
    input  logic [ADDR_WIDTH-1:0] resolve_pc,
    input  logic                  resolve_taken,
    input  logic [ADDR_WIDTH-1:0] resolve_target,
    input  logic                  resolve_pred_taken,
    input  logic [ADDR_WIDTH-1:0] resolve_pred_target,
    input  logic [GW-1:0]         resolve_ghr,
    output logic                  mispredict,
    output logic [ADDR_WIDTH-1:0] redirect_pc
);

    localparam int unsigned ENTRIES = 1 << INDEX_BITS;
    localparam int unsigned TAG_W   = ADDR_WIDTH - PC_LSB - INDEX_BITS;
    localparam bp_word_t    CTR_INIT_W = ctr_init(CTR_BITS);
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_INIT_W[CTR_BITS-1:0];

    logic [CTR_BITS-1:0]   ctr_q [ENTRIES];
    logic [GW-1:0]         ghr_q, ghr_d;
    bp_word_t              lk_ghr_w, rs_ghr_w, lk_idx_w, rs_idx_w, ctr_upd_w;
    logic [INDEX_BITS-1:0] lk_idx, rs_idx;
    logic [CTR_BITS-1:0]   lk_ctr, rs_ctr_next;
    logic [TAG_W-1:0]      lk_tag, rs_tag;
    logic                  btb_hit, btb_wr_en, lk_hit;
    logic [ADDR_WIDTH-1:0] btb_target;
    logic                  unused_bits;

    always_comb begin
        lk_ghr_w = '0;
        rs_ghr_w = '0;
        if (GHR_BITS > 0) begin
            lk_ghr_w = bp_word_t'(ghr_q);
            rs_ghr_w = bp_word_t'(resolve_ghr);
        end
        lk_idx_w    = bp_index(bp_word_t'(lookup_pc), lk_ghr_w, PC_LSB, INDEX_BITS);
        rs_idx_w    = bp_index(bp_word_t'(resolve_pc), rs_ghr_w, PC_LSB, INDEX_BITS);
        lk_idx      = lk_idx_w[INDEX_BITS-1:0];
        rs_idx      = rs_idx_w[INDEX_BITS-1:0];
        ctr_upd_w   = sat_next(bp_word_t'(ctr_q[rs_idx]), resolve_taken, CTR_BITS);
        rs_ctr_next = ctr_upd_w[CTR_BITS-1:0];
        lk_ctr      = ctr_q[lk_idx];
    end

    assign lk_tag = lookup_pc[ADDR_WIDTH-1 -: TAG_W];
    assign rs_tag = resolve_pc[ADDR_WIDTH-1 -: TAG_W];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_INIT;
            end
        end else if (resolve_valid) begin
            ctr_q[rs_idx] <= rs_ctr_next;
        end
    end

    assign btb_wr_en = reset && resolve_valid && resolve_taken;

    branch_target_buffer #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (TAG_W),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_btb (
        .clk         (clk),
        .reset       (reset),
        .rd_idx_i    (lk_idx),
        .rd_tag_i    (lk_tag),
        .rd_hit_o    (btb_hit),
        .rd_target_o (btb_target),
        .wr_en_i     (btb_wr_en),
        .wr_idx_i    (rs_idx),
        .wr_tag_i    (rs_tag),
        .wr_target_i (resolve_target)
    );

    assign lk_hit      = reset && lookup_valid && btb_hit;
    assign pred_taken  = lk_hit && lk_ctr[CTR_BITS-1];
    assign pred_target = lk_hit ? btb_target : '0;
    assign pred_ghr    = ghr_q;

    assign mispredict = reset && resolve_valid &&
                        ((resolve_taken != resolve_pred_taken) ||
                         (resolve_taken && resolve_pred_taken &&
                          (resolve_target != resolve_pred_target)));

    always_comb begin
        redirect_pc = '0;
        if (mispredict) begin
            redirect_pc = resolve_taken ? resolve_target : resolve_pc + ADDR_WIDTH'(4);
        end
    end

    // Repair from the EX-carried snapshot takes priority over the speculative shift.
    always_comb begin
        ghr_d = ghr_q;
        if (GHR_BITS == 0) begin
            ghr_d = '0;
        end else if (mispredict) begin
            ghr_d = (resolve_ghr << 1) | GW'(resolve_taken);
        end else if (lookup_valid) begin
            ghr_d = (ghr_q << 1) | GW'(pred_taken);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    assign unused_bits = ^{lk_idx_w, rs_idx_w, ctr_upd_w, lookup_pc, resolve_pc, resolve_ghr};

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed self-checking bench for branch_predictor_bht: a bimodal instance
// and a 3-bit gshare instance share stimulus.
module tb_branch_predictor_bht;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        lookup_valid = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic        resolve_valid = 1'b0;
    logic [31:0] resolve_pc = '0;
    logic        resolve_taken = 1'b0;
    logic [31:0] resolve_target = '0;
    logic        resolve_pred_taken = 1'b0;
    logic [31:0] resolve_pred_target = '0;
    logic [2:0]  resolve_ghr = '0;
    logic        resolve_ghr1 = 1'b0;

    logic        pred_taken, mispredict, pred_ghr_b;
    logic [31:0] pred_target, redirect_pc;
    logic        pred_taken_g, mispredict_g;
    logic [31:0] pred_target_g, redirect_pc_g;
    logic [2:0]  pred_ghr_g;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_predictor_bht #(
        .ADDR_WIDTH (32),
        .INDEX_BITS (3),
        .CTR_BITS   (2),
        .PC_LSB     (2),
        .GHR_BITS   (0)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .lookup_valid        (lookup_valid),
        .lookup_pc           (lookup_pc),
        .pred_taken          (pred_taken),
        .pred_target         (pred_target),
        .pred_ghr            (pred_ghr_b),
        .resolve_valid       (resolve_valid),
        .resolve_pc          (resolve_pc),
        .resolve_taken       (resolve_taken),
        .resolve_target      (resolve_target),
        .resolve_pred_taken  (resolve_pred_taken),
        .resolve_pred_target (resolve_pred_target),
        .resolve_ghr         (resolve_ghr1),
        .mispredict          (mispredict),
        .redirect_pc         (redirect_pc)
    );

    branch_predictor_bht #(
        .GHR_BITS (3)
    ) dut_g (
        .clk                 (clk),
        .reset               (reset),
        .lookup_valid        (lookup_valid),
        .lookup_pc           (lookup_pc),
        .pred_taken          (pred_taken_g),
        .pred_target         (pred_target_g),
        .pred_ghr            (pred_ghr_g),
        .resolve_valid       (resolve_valid),
        .resolve_pc          (resolve_pc),
        .resolve_taken       (resolve_taken),
        .resolve_target      (resolve_target),
        .resolve_pred_taken  (resolve_pred_taken),
        .resolve_pred_target (resolve_pred_target),
        .resolve_ghr         (resolve_ghr),
        .mispredict          (mispredict_g),
        .redirect_pc         (redirect_pc_g)
    );

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic set_lookup(input logic v, input logic [31:0] pc);
        lookup_valid = v;
        lookup_pc    = pc;
    endtask

    task automatic set_resolve(input logic v, input logic [31:0] pc, input logic tk,
                               input logic [31:0] tgt, input logic ptk,
                               input logic [31:0] ptgt, input logic [2:0] ghr);
        resolve_valid       = v;
        resolve_pc          = pc;
        resolve_taken       = tk;
        resolve_target      = tgt;
        resolve_pred_taken  = ptk;
        resolve_pred_target = ptgt;
        resolve_ghr         = ghr;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        set_lookup(1'b1, 32'h40);
        set_resolve(1'b1, 32'h40, 1'b1, 32'h300, 1'b0, 32'h0, 3'b000);
        #1;
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL rst_pred_taken got=%0h exp=0", pred_taken); end
        checks++; if (pred_target !== 32'h0) begin failures++; $display("FAIL rst_pred_target got=%0h exp=0", pred_target); end
        checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL rst_mispredict got=%0h exp=0", mispredict); end
        checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL rst_redirect got=%0h exp=0", redirect_pc); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        set_resolve(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000);
        set_lookup(1'b1, 32'h40);
        #1;
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL post_rst_pred_taken got=%0h exp=0", pred_taken); end
        checks++; if (pred_target !== 32'h0) begin failures++; $display("FAIL post_rst_pred_target got=%0h exp=0", pred_target); end
        checks++; if (pred_ghr_g !== 3'b000) begin failures++; $display("FAIL post_rst_ghr got=%0h exp=0", pred_ghr_g); end
    endtask

    task automatic test_allocate();
        @(negedge clk);
        set_lookup(1'b1, 32'h40);
        set_resolve(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 3'b000);
        #1;
        checks++; if (mispredict !== 1'b1) begin failures++; $display("FAIL alloc_mispredict got=%0h exp=1", mispredict); end
        checks++; if (redirect_pc !== 32'h100) begin failures++; $display("FAIL alloc_redirect got=%0h exp=100", redirect_pc); end
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL alloc_no_bypass got=%0h exp=0", pred_taken); end
        @(negedge clk);
        set_resolve(1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 3'b000);
        #1;
        checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL alloc_pred_taken got=%0h exp=1", pred_taken); end
        checks++; if (pred_target !== 32'h100) begin failures++; $display("FAIL alloc_pred_target got=%0h exp=100", pred_target); end
        checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL correct_pred_mispredict got=%0h exp=0", mispredict); end
        checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL correct_pred_redirect got=%0h exp=0", redirect_pc); end
    endtask

    // Counter at entry 0 starts at 3; walks down, holds at 0, back up, holds at 3.
    task automatic test_counter();
        bit          rv  [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        bit          tk  [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
        bit          ptk [10] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 0};
        bit          ep  [10] = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
        bit          em  [10] = '{1, 1, 1, 0, 1, 1, 0, 0, 1, 0};
        logic [31:0] er  [10] = '{32'h44, 32'h44, 32'h44, 32'h0, 32'h100,
                                  32'h100, 32'h0, 32'h0, 32'h44, 32'h0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            set_lookup(1'b1, 32'h40);
            set_resolve(rv[i], 32'h40, tk[i], 32'h100, ptk[i], 32'h100, 3'b000);
            #1;
            checks++; if (pred_taken !== ep[i]) begin failures++; $display("FAIL ctr_pred[%0d] got=%0h exp=%0h", i, pred_taken, ep[i]); end
            checks++; if (mispredict !== em[i]) begin failures++; $display("FAIL ctr_mispredict[%0d] got=%0h exp=%0h", i, mispredict, em[i]); end
            checks++; if (redirect_pc !== er[i]) begin failures++; $display("FAIL ctr_redirect[%0d] got=%0h exp=%0h", i, redirect_pc, er[i]); end
        end
    endtask

    task automatic test_alias();
        @(negedge clk);
        set_lookup(1'b0, 32'h0);
        set_resolve(1'b1, 32'h60, 1'b1, 32'h200, 1'b0, 32'h0, 3'b000);
        #1;
        checks++; if (redirect_pc !== 32'h200) begin failures++; $display("FAIL alias_redirect got=%0h exp=200", redirect_pc); end
        @(negedge clk);
        set_resolve(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000);
        set_lookup(1'b1, 32'h40);
        #1;
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL alias_miss_pred got=%0h exp=0", pred_taken); end
        checks++; if (pred_target !== 32'h0) begin failures++; $display("FAIL alias_miss_target got=%0h exp=0", pred_target); end
        @(negedge clk);
        set_lookup(1'b1, 32'h60);
        #1;
        checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL alias_hit_pred got=%0h exp=1", pred_taken); end
        checks++; if (pred_target !== 32'h200) begin failures++; $display("FAIL alias_hit_target got=%0h exp=200", pred_target); end
    endtask

    task automatic test_target_mismatch();
        @(negedge clk);
        set_lookup(1'b0, 32'h0);
        set_resolve(1'b1, 32'h40, 1'b1, 32'h180, 1'b1, 32'h100, 3'b000);
        #1;
        checks++; if (mispredict !== 1'b1) begin failures++; $display("FAIL tgt_mispredict got=%0h exp=1", mispredict); end
        checks++; if (redirect_pc !== 32'h180) begin failures++; $display("FAIL tgt_redirect got=%0h exp=180", redirect_pc); end
        @(negedge clk);
        set_resolve(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000);
        set_lookup(1'b1, 32'h40);
        #1;
        checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL tgt_pred got=%0h exp=1", pred_taken); end
        checks++; if (pred_target !== 32'h180) begin failures++; $display("FAIL tgt_overwrite got=%0h exp=180", pred_target); end
        @(negedge clk);
        set_lookup(1'b0, 32'h40);
        #1;
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL nolookup_pred got=%0h exp=0", pred_taken); end
        checks++; if (pred_target !== 32'h0) begin failures++; $display("FAIL nolookup_target got=%0h exp=0", pred_target); end
    endtask

    task automatic test_ghr();
        logic [31:0] pcs  [3] = '{32'h40, 32'h44, 32'h4C};
        logic [2:0]  ghrs [3] = '{3'b000, 3'b001, 3'b011};
        @(negedge clk);
        reset = 1'b0;
        set_lookup(1'b0, 32'h0);
        set_resolve(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000);
        @(negedge clk);
        reset = 1'b1;
        set_resolve(1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 3'b000);
        #1;
        checks++; if (mispredict_g !== 1'b0) begin failures++; $display("FAIL ghr_alloc_mispredict got=%0h exp=0", mispredict_g); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_resolve(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000);
            set_lookup(1'b1, pcs[i]);
            #1;
            checks++; if (pred_ghr_g !== ghrs[i]) begin failures++; $display("FAIL ghr_snap[%0d] got=%0h exp=%0h", i, pred_ghr_g, ghrs[i]); end
            checks++; if (pred_taken_g !== 1'b1) begin failures++; $display("FAIL ghr_pred[%0d] got=%0h exp=1", i, pred_taken_g); end
        end
        @(negedge clk);
        set_lookup(1'b0, 32'h0);
        #1;
        checks++; if (pred_ghr_g !== 3'b111) begin failures++; $display("FAIL ghr_three_taken got=%0h exp=7", pred_ghr_g); end
        @(negedge clk);
        set_lookup(1'b1, 32'h40);
        set_resolve(1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h100, 3'b010);
        #1;
        checks++; if (mispredict_g !== 1'b1) begin failures++; $display("FAIL ghr_repair_mispredict got=%0h exp=1", mispredict_g); end
        checks++; if (redirect_pc_g !== 32'h44) begin failures++; $display("FAIL ghr_repair_redirect got=%0h exp=44", redirect_pc_g); end
        @(negedge clk);
        set_lookup(1'b0, 32'h0);
        set_resolve(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000);
        #1;
        checks++; if (pred_ghr_g !== 3'b100) begin failures++; $display("FAIL ghr_repair got=%0h exp=4", pred_ghr_g); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_lookup(1'b0, 32'h0);
            set_resolve(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000);
        end
        @(negedge clk);
        set_resolve(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000);
        set_lookup(1'b1, 32'h40);
        #1;
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL mid_pre_pred got=%0h exp=0", pred_taken); end
        checks++; if (pred_target !== 32'h100) begin failures++; $display("FAIL mid_pre_target got=%0h exp=100", pred_target); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (pred_target !== 32'h0) begin failures++; $display("FAIL mid_btb_cleared got=%0h exp=0", pred_target); end
        @(negedge clk);
        set_lookup(1'b0, 32'h0);
        set_resolve(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 3'b000);
        @(negedge clk);
        set_resolve(1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h100, 3'b000);
        @(negedge clk);
        set_resolve(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000);
        set_lookup(1'b1, 32'h40);
        #1;
        checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL mid_ctr_weak_taken got=%0h exp=1", pred_taken); end
    endtask

    initial begin
        test_reset();
        test_allocate();
        test_counter();
        test_alias();
        test_target_mismatch();
        test_ghr();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_predictor_bht.md
Name: branch_predictor_bht

Overview:
- Parametrised successor to the 8-entry branch hazard unit.
- Provides a direct-mapped branch history table (BHT) of N-bit saturating counters, plus a branch target buffer (BTB) with tags and targets.
- Has an optional global-history (gshare) index mode and separate fetch-lookup and EX-resolve ports, so prediction and update never share one PC.
- Sits between IF (lookup, same cycle) and the ALU/EX stage (resolve); drives the pipeline flush and redirect.

Parameters:
- ADDR_WIDTH, 32, PC and target width.
- INDEX_BITS, 3, log2 of table entries (BHT and BTB share the index; 8 entries by default).
- CTR_BITS, 2, saturating counter width (at least 1).
- PC_LSB, 2, lowest PC bit used in the index (word-aligned instructions).
- GHR_BITS, 0, global history length; 0 = bimodal; 1..INDEX_BITS = gshare (index XOR GHR).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- lookup_valid  input  1  IF stage presents a PC this cycle.
- lookup_pc  input  ADDR_WIDTH  fetch PC.
- pred_taken  output  1  predict taken (BTB hit AND counter MSB = 1).
- pred_target  output  ADDR_WIDTH  BTB target; 0 when no hit.
- pred_ghr  output  max(GHR_BITS,1)  GHR snapshot used for this lookup, carried down the pipeline.
- resolve_valid  input  1  EX stage has a resolved conditional branch.
- resolve_pc  input  ADDR_WIDTH  PC of the resolved branch.
- resolve_taken  input  1  actual outcome.
- resolve_target  input  ADDR_WIDTH  actual taken target.
- resolve_pred_taken  input  1  prediction carried from IF.
- resolve_pred_target  input  ADDR_WIDTH  predicted target carried from IF.
- resolve_ghr  input  max(GHR_BITS,1)  pred_ghr carried from IF.
- mispredict  output  1  flush IF/ID and ID/EX.
- redirect_pc  output  ADDR_WIDTH  correct next PC when mispredict = 1.

Behaviour:
- Index:
  - lkidx = lookup_pc[PC_LSB+INDEX_BITS-1:PC_LSB], XOR zero-extended GHR when GHR_BITS > 0.
  - rsidx is formed the same way from resolve_pc and resolve_ghr.
- Tag: pc[ADDR_WIDTH-1:PC_LSB+INDEX_BITS].
- Lookup is combinational, zero latency, and reads registered state. A resolve update in the same cycle is not bypassed; lookup sees the pre-edge value.
- When lookup_valid = 0: pred_taken = 0, pred_target = 0.
- Reset (reset = 0 at a clock edge), all state cleared in one cycle:
  - every counter = 1<<(CTR_BITS-1) (weakly taken; 2'b10 for 2 bits);
  - all BTB valid bits = 0;
  - GHR = 0.
  - While reset = 0, pred_taken = 0, pred_target = 0, mispredict = 0, redirect_pc = 0.
  - Reset mid-operation discards all history.
- Counter update on resolve_valid:
  - taken: saturating +1, max 2^CTR_BITS-1;
  - not taken: saturating -1, min 0;
  - no wrap in either direction.
- BTB update on resolve_valid && resolve_taken: write valid = 1, tag and target at rsidx (allocate or overwrite). Not-taken branches never allocate and never invalidate.
- mispredict = resolve_valid && ((resolve_taken != resolve_pred_taken) || (resolve_taken && resolve_pred_taken && resolve_target != resolve_pred_target)). Combinational.
- redirect_pc = resolve_taken ? resolve_target : resolve_pc + 4, truncated to ADDR_WIDTH. Value is 0 when mispredict = 0.
- GHR (only when GHR_BITS > 0):
  - on lookup_valid, GHR <= {GHR[GHR_BITS-2:0], pred_taken} (speculative);
  - on mispredict, GHR <= {resolve_ghr[GHR_BITS-2:0], resolve_taken} (repair);
  - repair wins over a simultaneous lookup shift.
- Both arrays hold no pending state, so no stall port exists. Simultaneous lookup and resolve to the same index is legal.

Decomposition:
- Package branch_pred_pkg holds:
  - the counter encodings as constants: STRONG_NT = 0, WEAK_NT, WEAK_T, STRONG_T for CTR_BITS = 2, and the generic weak-taken init value;
  - a function sat_next(ctr, taken);
  - a function bp_index(pc, ghr).
- One sub-module, branch_target_buffer: tag/target/valid arrays with one combinational read port and one synchronous write port.
- The counters stay in the top level.

Test Plan:
- Reset, then lookup_valid = 1, lookup_pc = 0x40 -> pred_taken = 0 (BTB miss), pred_target = 0.
- Resolve pc = 0x40, taken = 1, target = 0x100, pred_taken = 0 -> mispredict = 1, redirect_pc = 0x100. Next cycle, lookup of 0x40 -> pred_taken = 1, pred_target = 0x100.
- Resolve pc = 0x40 not-taken three times, each with pred_taken = 1:
  - counter goes 3 -> 2 -> 1 -> 0, with no underflow on a fourth not-taken;
  - mispredict = 1 with redirect_pc = 0x44 while the prediction was taken;
  - lookup predicts not taken once the counter is at or below 1.
- Aliasing: with INDEX_BITS = 3, resolve pc 0x40 taken to 0x100, then pc 0x60 taken to 0x200 -> a lookup of 0x40 misses on tag (pred_taken = 0).
- Target mismatch: resolve taken, pred_taken = 1, pred_target = 0x100, actual target = 0x180 -> mispredict = 1, redirect_pc = 0x180, and the BTB is overwritten.
- GHR_BITS = 3:
  - three taken lookups -> pred_ghr = 3'b111;
  - mispredict with resolve_ghr = 3'b010 and taken = 0, in the same cycle as a lookup -> GHR = 3'b100.
- Assert reset mid-stream -> all counters return to weakly taken and all BTB valid bits clear.
